// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: serializes parallel configuration words LSB-first onto the
// head of a ccff configuration chain. At the same time it captures the old chain
// contents from ccff_tail and returns them as parallel readback words.
module ccff_stream_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clock,
  input  logic              global_reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam int TC_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [TC_W-1:0]   total_cnt;
  logic [WB_W-1:0]   word_bit_cnt;
  logic [WORD_W-1:0] tx_sreg;
  logic [WORD_W-1:0] rx_sreg;
  logic [WORD_W-1:0] rx_next;
  logic              chain_last;
  logic              word_last;

  // Readback word including the tail bit captured at the coming edge, plus
  // last-bit detection. Counters are compared against the final index so the
  // exit decision and the capture of the final bit happen at the same edge.
  always_comb begin
    rx_next               = rx_sreg;
    rx_next[word_bit_cnt] = ccff_tail;
    chain_last            = (total_cnt == TC_W'(CHAIN_LEN - 1));
    word_last             = (word_bit_cnt == WB_W'(WORD_W - 1));
  end

  // Load sequencer: handshake, shift, readback capture and registered outputs.
  always_ff @(posedge prog_clock) begin
    if (global_reset) begin
      state         <= IDLE;
      total_cnt     <= '0;
      word_bit_cnt  <= '0;
      tx_sreg       <= '0;
      rx_sreg       <= '0;
      word_ready    <= 1'b0;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= WAIT_WORD;
            total_cnt  <= '0;
            word_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        WAIT_WORD: begin
          if (word_valid && word_ready) begin
            state         <= SHIFT;
            tx_sreg       <= word_data;
            rx_sreg       <= '0;
            word_bit_cnt  <= '0;
            ccff_head     <= word_data[0];
            config_enable <= 1'b1;
            word_ready    <= 1'b0;
          end
        end
        SHIFT: begin
          tx_sreg      <= tx_sreg >> 1;
          rx_sreg      <= rx_next;
          word_bit_cnt <= word_bit_cnt + 1'b1;
          total_cnt    <= total_cnt + 1'b1;
          // End of chain wins over end of word, so surplus input bits are never driven.
          if (chain_last) begin
            state         <= DONE;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            rd_valid      <= 1'b1;
            rd_data       <= rx_next;
            done          <= 1'b1;
          end else if (word_last) begin
            state         <= WAIT_WORD;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            word_ready    <= 1'b1;
            rd_valid      <= 1'b1;
            rd_data       <= rx_next;
          end else begin
            ccff_head <= tx_sreg[1];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed testbench for ccff_stream_loader: a 12-bit and a 16-bit chain, each
// modelled as a shift register fed by ccff_head and clocked by config_enable.
module tb_ccff_stream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       global_reset;
  logic       start12, start16;
  logic       word_valid;
  logic [7:0] word_data;

  logic       word_ready12, head12, ce12, tail12, rdv12, busy12, done12;
  logic [7:0] rdd12;
  logic       word_ready16, head16, ce16, tail16, rdv16, busy16, done16;
  logic [7:0] rdd16;

  logic [11:0] chain12;
  logic [15:0] chain16;
  logic        load12, load16;
  logic [11:0] load12_val;
  logic [15:0] load16_val;

  ccff_stream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clock   (clk),
    .global_reset (global_reset),
    .start        (start12),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready12),
    .ccff_head    (head12),
    .config_enable(ce12),
    .ccff_tail    (tail12),
    .rd_valid     (rdv12),
    .rd_data      (rdd12),
    .busy         (busy12),
    .done         (done12)
  );

  ccff_stream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clock   (clk),
    .global_reset (global_reset),
    .start        (start16),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready16),
    .ccff_head    (head16),
    .config_enable(ce16),
    .ccff_tail    (tail16),
    .rd_valid     (rdv16),
    .rd_data      (rdd16),
    .busy         (busy16),
    .done         (done16)
  );

  // Downstream chain models: bit 0 is the tail, new bits enter at the top.
  always @(posedge clk) begin
    if (load12) chain12 <= load12_val;
    else if (ce12) chain12 <= {head12, chain12[11:1]};
    if (load16) chain16 <= load16_val;
    else if (ce16) chain16 <= {head16, chain16[15:1]};
  end
  assign tail12 = chain12[0];
  assign tail16 = chain16[0];

  int checks = 0;
  int errors = 0;

  int          ce12_cnt, rd12_cnt, done12_cnt, coin12, busy12_cnt;
  logic [31:0] hb12;
  logic [7:0]  rd12_w [4];
  int          ce16_cnt, rd16_cnt, done16_cnt, coin16, busy16_cnt, ready16_after;
  logic [7:0]  rd16_w [4];
  logic        mark16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ce12_cnt = 0; rd12_cnt = 0; done12_cnt = 0; coin12 = 0; busy12_cnt = 0; hb12 = '0;
    ce16_cnt = 0; rd16_cnt = 0; done16_cnt = 0; coin16 = 0; busy16_cnt = 0;
    ready16_after = 0; mark16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd12_w[i] = '0;
      rd16_w[i] = '0;
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ce12) begin
      if (ce12_cnt < 32) hb12[ce12_cnt] = head12;
      ce12_cnt++;
    end
    if (rdv12) begin
      if (rd12_cnt < 4) rd12_w[rd12_cnt] = rdd12;
      rd12_cnt++;
      if (done12) coin12++;
    end
    if (done12) done12_cnt++;
    if (busy12) busy12_cnt++;
    if (ce16) ce16_cnt++;
    if (rdv16) begin
      if (rd16_cnt < 4) rd16_w[rd16_cnt] = rdd16;
      rd16_cnt++;
      if (done16) coin16++;
    end
    if (done16) done16_cnt++;
    if (busy16) busy16_cnt++;
    if (mark16 && word_ready16) ready16_after++;
  endtask

  function automatic logic [31:0] idle_vec12();
    return {18'd0, word_ready12, head12, ce12, rdv12, busy12, done12, rdd12};
  endfunction

  function automatic logic [31:0] idle_vec16();
    return {18'd0, word_ready16, head16, ce16, rdv16, busy16, done16, rdd16};
  endfunction

  task automatic preload12(input logic [11:0] v);
    load12_val = v; load12 = 1'b1; tick(); load12 = 1'b0;
  endtask

  // Full 12-bit load of two words; optional stall before word 1 and a
  // start pulse while shifting word 0.
  task automatic run12(input logic [7:0] w0, input logic [7:0] w1, input int stall, input bit poke);
    int n;
    logic [11:0] snap;
    int ce_snap;
    clear_mon();
    start12 = 1'b1; tick(); start12 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      while (!word_ready12 && n < 100) begin
        start12 = (poke && w == 1 && n == 3);
        tick();
        n++;
      end
      start12 = 1'b0;
      check("word_ready_wait", {31'd0, word_ready12}, 32'd1);
      if (w == 1 && stall > 0) begin
        snap = chain12; ce_snap = ce12_cnt;
        for (int s = 0; s < stall; s++) tick();
        check("stall_no_enable", ce12_cnt, ce_snap);
        check("stall_chain_held", {20'd0, chain12}, {20'd0, snap});
        check("stall_ready_held", {31'd0, word_ready12}, 32'd1);
      end
      word_valid = 1'b1; word_data = (w == 0) ? w0 : w1;
      tick();
      word_valid = 1'b0;
      if (w == 0) check("first_bit_latency", {30'd0, ce12, head12}, {30'd0, 1'b1, w0[0]});
    end
    n = 0;
    while (!done12 && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done12}, 32'd1);
    tick();
  endtask

  task automatic verify12(input string tag, input logic [11:0] hb, input logic [7:0] r0,
                          input logic [7:0] r1, input int bcyc);
    check({tag, "_enable_count"}, ce12_cnt, 12);
    check({tag, "_head_bits"}, hb12, {20'd0, hb});
    check({tag, "_rd_count"}, rd12_cnt, 2);
    check({tag, "_rd0"}, {24'd0, rd12_w[0]}, {24'd0, r0});
    check({tag, "_rd1"}, {24'd0, rd12_w[1]}, {24'd0, r1});
    check({tag, "_done_count"}, done12_cnt, 1);
    check({tag, "_done_with_rd"}, coin12, 1);
    check({tag, "_busy_cycles"}, busy12_cnt, bcyc);
    check({tag, "_idle_after"}, {31'd0, busy12}, 32'd0);
    check({tag, "_chain_after"}, {20'd0, chain12}, {20'd0, hb});
  endtask

  initial begin
    int n;
    global_reset = 1'b1;
    start12 = 1'b0; start16 = 1'b0;
    word_valid = 1'b0; word_data = '0;
    load12 = 1'b0; load16 = 1'b0; load12_val = '0; load16_val = '0;
    clear_mon();
    tick(); tick();
    check("reset_outputs12", idle_vec12(), 32'd0);
    check("reset_outputs16", idle_vec16(), 32'd0);
    global_reset = 1'b0;
    tick();

    // Basic load: words A5, 0F into a chain holding 3C, 05.
    preload12(12'h53C);
    run12(8'hA5, 8'h0F, 0, 1'b0);
    verify12("basic", 12'hFA5, 8'h3C, 8'h05, 15);

    // Back-to-back start with a 5-cycle word stall; readback is the previous load.
    run12(8'h5A, 8'h03, 5, 1'b0);
    verify12("stall", 12'h35A, 8'hA5, 8'h0F, 20);

    // start pulsed during SHIFT is ignored.
    run12(8'hC3, 8'h09, 0, 1'b1);
    verify12("poke", 12'h9C3, 8'h5A, 8'h03, 15);
    tick(); tick(); tick();
    check("poke_no_restart", {31'd0, busy12}, 32'd0);

    // Reset after the third shift of word 0.
    preload12(12'h9C3);
    clear_mon();
    start12 = 1'b1; tick(); start12 = 1'b0;
    word_valid = 1'b1; word_data = 8'h77; tick(); word_valid = 1'b0;
    tick(); tick();
    global_reset = 1'b1;
    tick();
    check("abort_outputs", idle_vec12(), 32'd0);
    check("abort_enable_count", ce12_cnt, 3);
    check("abort_no_readback", rd12_cnt, 0);
    global_reset = 1'b0;
    tick(); tick(); tick();
    check("abort_quiet_after", ce12_cnt, 3);
    check("abort_chain", {20'd0, chain12}, 32'h0000_0F38);
    preload12(12'h53C);
    run12(8'hA5, 8'h0F, 0, 1'b0);
    verify12("reload", 12'hFA5, 8'h3C, 8'h05, 15);

    // Exact multiple: 16-bit chain, two full words.
    load16_val = 16'hBEEF; load16 = 1'b1; tick(); load16 = 1'b0;
    clear_mon();
    start16 = 1'b1; tick(); start16 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      while (!word_ready16 && n < 100) begin
        tick();
        n++;
      end
      check("w16_ready_wait", {31'd0, word_ready16}, 32'd1);
      word_valid = 1'b1; word_data = (w == 0) ? 8'h12 : 8'h34;
      tick();
      word_valid = 1'b0;
    end
    mark16 = 1'b1;
    n = 0;
    while (!done16 && n < 100) begin
      tick();
      n++;
    end
    check("w16_done_seen", {31'd0, done16}, 32'd1);
    tick();
    check("w16_enable_count", ce16_cnt, 16);
    check("w16_rd_count", rd16_cnt, 2);
    check("w16_rd0", {24'd0, rd16_w[0]}, 32'h0000_00EF);
    check("w16_rd1", {24'd0, rd16_w[1]}, 32'h0000_00BE);
    check("w16_done_count", done16_cnt, 1);
    check("w16_done_with_rd", coin16, 1);
    check("w16_no_third_word", ready16_after, 0);
    check("w16_busy_cycles", busy16_cnt, 19);
    check("w16_chain_after", {16'd0, chain16}, 32'h0000_3412);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
